// File: rtl/regfile_write_arbiter.sv
// Two-source round-robin arbiter for the single RegisterFile write port, with a saturating conflict counter.
// Optional read bypass of the in-flight write is enabled by defining REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DROP_R0 = 1,
    parameter int CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              aValid,
    input  logic [ADDR_W-1:0] aReg,
    input  logic [DATA_W-1:0] aData,
    output logic              aReady,
    input  logic              bValid,
    input  logic [ADDR_W-1:0] bReg,
    input  logic [DATA_W-1:0] bData,
    output logic              bReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
`ifdef REGFILE_ARB_BYPASS_EN
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    input  logic [DATA_W-1:0] rfData1,
    input  logic [DATA_W-1:0] rfData2,
    output logic [DATA_W-1:0] fwdData1,
    output logic [DATA_W-1:0] fwdData2,
`endif
    output logic [CNT_W-1:0]  conflictCnt
);

    // Handshake: a write transfers in any cycle where xValid & xReady; the requester
    // holds reg/data stable until then and may withdraw by dropping valid.
    logic              r_prio_b;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic              w_conflict;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_drop;

    assign w_conflict = aValid & bValid;
    assign w_grant_a  = Reset & aValid & (~bValid | ~r_prio_b);
    assign w_grant_b  = Reset & bValid & (~aValid | r_prio_b);
    assign w_accept   = w_grant_a | w_grant_b;
    assign w_sel_reg  = w_grant_a ? aReg  : bReg;
    assign w_sel_data = w_grant_a ? aData : bData;
    // Writes to r0 complete the handshake but never reach the RegisterFile.
    assign w_drop     = (DROP_R0 != 0) && (w_sel_reg == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_prio_b       <= 1'b0;
            r_reg_write    <= 1'b0;
            r_write_reg    <= '0;
            r_write_data   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_reg_write <= w_accept & ~w_drop;
            if (w_accept && !w_drop) begin
                r_write_reg  <= w_sel_reg;
                r_write_data <= w_sel_data;
            end
            // Pointer always moves to the requester that was not served.
            if (w_grant_a) begin
                r_prio_b <= 1'b1;
            end else if (w_grant_b) begin
                r_prio_b <= 1'b0;
            end
            if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign aReady      = w_grant_a;
    assign bReady      = w_grant_b;
    assign RegWrite    = r_reg_write;
    assign writeReg    = r_write_reg;
    assign writeData   = r_write_data;
    assign conflictCnt = r_conflict_cnt;

`ifdef REGFILE_ARB_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Covers the cycle where the RegisterFile has not yet absorbed the issued write.
    assign w_hit1   = r_reg_write && (r_write_reg == reg1) && ((DROP_R0 == 0) || (reg1 != '0));
    assign w_hit2   = r_reg_write && (r_write_reg == reg2) && ((DROP_R0 == 0) || (reg2 != '0));
    assign fwdData1 = w_hit1 ? r_write_data : rfData1;
    assign fwdData2 = w_hit2 ? r_write_data : rfData2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: driver checks grants, a monitor checks issued writes
// against a queue of expected {reg,data}; a second instance with CNT_W=2 checks counter saturation.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Reset;
    logic        aValid;
    logic [4:0]  aReg;
    logic [31:0] aData;
    logic        aReady;
    logic        bValid;
    logic [4:0]  bReg;
    logic [31:0] bData;
    logic        bReady;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [15:0] conflictCnt;

    logic        aReady2;
    logic        bReady2;
    logic        RegWrite2;
    logic [4:0]  writeReg2;
    logic [31:0] writeData2;
    logic [1:0]  conflictCnt2;

`ifdef REGFILE_ARB_BYPASS_EN
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [31:0] rfData1;
    logic [31:0] rfData2;
    logic [31:0] fwdData1;
    logic [31:0] fwdData2;
    logic [31:0] fwdData1_2;
    logic [31:0] fwdData2_2;
`endif

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    regfile_write_arbiter u_dut (
        .Clk(Clk), .Reset(Reset),
        .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
`ifdef REGFILE_ARB_BYPASS_EN
        .reg1(reg1), .reg2(reg2), .rfData1(rfData1), .rfData2(rfData2),
        .fwdData1(fwdData1), .fwdData2(fwdData2),
`endif
        .conflictCnt(conflictCnt)
    );

    regfile_write_arbiter #(.CNT_W(2)) u_dut_sat (
        .Clk(Clk), .Reset(Reset),
        .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady2),
        .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady2),
        .RegWrite(RegWrite2), .writeReg(writeReg2), .writeData(writeData2),
`ifdef REGFILE_ARB_BYPASS_EN
        .reg1(reg1), .reg2(reg2), .rfData1(rfData1), .rfData2(rfData2),
        .fwdData1(fwdData1_2), .fwdData2(fwdData2_2),
`endif
        .conflictCnt(conflictCnt2)
    );

    // Clock and watchdog
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every issued write must match the oldest expected write
    always @(negedge Clk) begin
        if (Reset === 1'b1 && RegWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got r%0d=%0h, required no write", writeReg, writeData);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({writeReg, writeData} !== e) begin
                    errors++;
                    $display("FAIL write_port: got r%0d=%0h, required r%0d=%0h",
                             writeReg, writeData, e[36:32], e[31:0]);
                end
            end
        end
    end

    // Drive one cycle of requests starting just after a rising edge; returns just after the next one.
    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic ea, input logic eb, input logic push, input string tag);
        aValid = av; aReg = ar; aData = ad;
        bValid = bv; bReg = br; bData = bd;
        @(negedge Clk);
        chk({tag, "_aReady"}, {63'd0, aReady}, {63'd0, ea});
        chk({tag, "_bReady"}, {63'd0, bReady}, {63'd0, eb});
        if (push && ea && ar != 5'd0) exp_q.push_back({ar, ad});
        if (push && eb && br != 5'd0) exp_q.push_back({br, bd});
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (3) begin
            aValid = 1'($urandom_range(0, 1));
            bValid = 1'($urandom_range(0, 1));
            aReg   = 5'($urandom_range(0, 31));
            bReg   = 5'($urandom_range(0, 31));
            @(negedge Clk);
            chk("rst_aReady", {63'd0, aReady}, 64'd0);
            chk("rst_bReady", {63'd0, bReady}, 64'd0);
            chk("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
            chk("rst_writeReg", {59'd0, writeReg}, 64'd0);
            chk("rst_writeData", {32'd0, writeData}, 64'd0);
            chk("rst_conflictCnt", {48'd0, conflictCnt}, 64'd0);
            @(posedge Clk);
            #1;
        end
        aValid = 1'b0;
        bValid = 1'b0;
        Reset  = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        aValid = 1'b0; aReg = 5'd0; aData = 32'd0;
        bValid = 1'b0; bReg = 5'd0; bData = 32'd0;
`ifdef REGFILE_ARB_BYPASS_EN
        reg1 = 5'd15; reg2 = 5'd16; rfData1 = 32'd0; rfData2 = 32'hDEAD_BEEF;
`endif
        @(posedge Clk);
        #1;

        // Reset with random valids, then idle
        do_reset();
        idle("idle0");
        chk("idle_RegWrite", {63'd0, RegWrite}, 64'd0);

        // Single A write, issued one cycle later
        drive(1'b1, 5'd15, 32'h1871, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, "t2");
        chk("t2_RegWrite", {63'd0, RegWrite}, 64'd1);
`ifdef REGFILE_ARB_BYPASS_EN
        chk("byp_fwd1_hit", {32'd0, fwdData1}, 64'h1871);
        chk("byp_fwd2_miss", {32'd0, fwdData2}, 64'hDEAD_BEEF);
`endif
        idle("t2_idle");
        chk("t2_RegWrite_off", {63'd0, RegWrite}, 64'd0);
        chk("t2_writeReg_hold", {59'd0, writeReg}, 64'd15);
`ifdef REGFILE_ARB_BYPASS_EN
        chk("byp_fwd1_nowrite", {32'd0, fwdData1}, 64'd0);
`endif

        // Conflict held 4 cycles from priority A: A,B,A,B
        do_reset();
        drive(1'b1, 5'd16, 32'h1249, 1'b1, 5'd17, 32'hABCD, 1'b1, 1'b0, 1'b1, "t3_c1");
        drive(1'b1, 5'd16, 32'h1249, 1'b1, 5'd17, 32'hABCD, 1'b0, 1'b1, 1'b1, "t3_c2");
        chk("t3_RegWrite_c2", {63'd0, RegWrite}, 64'd1);
        drive(1'b1, 5'd16, 32'h1249, 1'b1, 5'd17, 32'hABCD, 1'b1, 1'b0, 1'b1, "t3_c3");
        chk("t3_RegWrite_c3", {63'd0, RegWrite}, 64'd1);
        drive(1'b1, 5'd16, 32'h1249, 1'b1, 5'd17, 32'hABCD, 1'b0, 1'b1, 1'b1, "t3_c4");
        chk("t3_RegWrite_c4", {63'd0, RegWrite}, 64'd1);
        chk("t3_conflictCnt", {48'd0, conflictCnt}, 64'd4);
        chk("t3_sat_cnt", {62'd0, conflictCnt2}, 64'd3);
        drive(1'b1, 5'd18, 32'h5555, 1'b1, 5'd19, 32'h6666, 1'b1, 1'b0, 1'b1, "t3_c5");
        chk("t3_conflictCnt5", {48'd0, conflictCnt}, 64'd5);
        chk("t3_sat_cnt5", {62'd0, conflictCnt2}, 64'd3);

        // B write to r0 is accepted but dropped
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, "t4");
        chk("t4_RegWrite", {63'd0, RegWrite}, 64'd0);

        // B loses and withdraws; only A writes are issued
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, "wd_c1");
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, "wd_c2");

        // Back-to-back A writes, no bubbles
        drive(1'b1, 5'd8, 32'h8888_0001, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, "b2b_1");
        drive(1'b1, 5'd9, 32'h9999_0002, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, "b2b_2");
        chk("b2b_RegWrite", {63'd0, RegWrite}, 64'd1);
        drive(1'b1, 5'd10, 32'hAAAA_0003, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, "b2b_3");
        chk("b2b_RegWrite3", {63'd0, RegWrite}, 64'd1);

        // Pointer now favours B; that write is discarded by a reset pulse
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55, 1'b0, 1'b1, 1'b0, "t5_pre");
        aValid = 1'b0;
        bValid = 1'b0;
        Reset  = 1'b0;
        #1;
        chk("t5_RegWrite", {63'd0, RegWrite}, 64'd0);
        chk("t5_conflictCnt", {48'd0, conflictCnt}, 64'd0);
        chk("t5_sat_cnt", {62'd0, conflictCnt2}, 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b1, "t5_post");
        chk("t5_post_cnt", {48'd0, conflictCnt}, 64'd1);
        idle("end_idle1");
        idle("end_idle2");
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
